// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem address generation, decode-stage
// instruction register, and branch redirect / stall / halt control.
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_unit #(
  parameter int                     PC_W       = 64,
  parameter logic [PC_W-1:0]        RESET_PC   = 64'h0,
  parameter logic [`INSTR_LEN-1:0]  HALT_INSTR = 32'hD4400000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_W-1:0]        br_pc,
  input  logic [25:0]            br_offset,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [`INSTR_LEN-1:0]  imem_rdata,
  output logic [`INSTR_LEN-1:0]  instr,
  output logic [PC_W-1:0]        instr_pc,
  output logic                   instr_valid,
  output logic                   halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

  typedef struct packed {
    logic [`INSTR_LEN-1:0] instr;
    logic [PC_W-1:0]       pc;
    logic                  vld;
  } fetch_out_t;

  state_e          state;
  fetch_out_t      fo;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_inc;
  logic            is_halt;

  // imm26 is a word offset: sign-extend then scale by 4, wrapping modulo 2^PC_W.
  assign br_target = br_pc + {{(PC_W-28){br_offset[25]}}, br_offset, 2'b00};
  assign pc_inc    = pc + PC_W'(4);
  assign is_halt   = (imem_rdata == HALT_INSTR);

  assign imem_addr   = pc;
  assign instr       = fo.instr;
  assign instr_pc    = fo.pc;
  assign instr_valid = fo.vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      fo     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (branch_taken) begin
            // Redirect wins over stall and halt; the slot becomes a bubble.
            pc     <= br_target;
            fo.vld <= 1'b0;
          end else if (!stall) begin
            fo.instr <= imem_rdata;
            fo.pc    <= pc;
            fo.vld   <= 1'b1;
            if (is_halt) state <= HALT;
            else         pc    <= pc_inc;
          end
        end
        HALT: begin
          fo.vld <= 1'b0;
          halted <= 1'b1;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
